// File: rtl/mmio_uart_ctr.sv
// ============================================================================
// mmio_uart_ctr -- MMIO peripheral: UART with RX FIFO (optional TX FIFO) plus
// cycle, retired-instruction and generic event counters.
//
// Optional feature macro: MMIO_TX_FIFO_EN
//   defined   : TX writes are queued in a TX_DEPTH FIFO that drains into the uart.
//   undefined : TX writes go straight to the uart and are dropped if it is busy.
//
// Address map (byte offsets, addr[15:0]):
//   0x00 CTRL  RO  {29'b0, rx_ovf, rx_valid, tx_ready}
//   0x04 RX    RO  pops one byte (0 when empty)
//   0x08 TX    WO  pushes wdata[7:0]
//   0x10 CYC   RO  cycle counter
//   0x14 INST  RO  retired-instruction counter
//   0x18 CRST  WO  any write clears all counters and rx_ovf
//   0x20+4k    RO  EVT[k], k < NUM_EVT
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rd_en, wr_en     MMIO strobes (mutually exclusive)
//   addr, wdata      MMIO byte offset and write data
//   rdata            registered read data, 1-cycle latency, held between reads
//   inst_valid       a real instruction retires this cycle
//   evt_in           per-cycle event pulses, one per event counter
//   serial_in/out    UART line
//
// Also contains the uart (uart_tx + uart_rx) used by the peripheral.
// ============================================================================

// ----------------------------------------------------------------------------
// uart_tx -- 8N1 transmitter. data_in_ready is high while idle; a byte is
// accepted on data_in_valid && data_in_ready and shifted out LSB first.
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);
    localparam int SYM = CLOCK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(SYM) + 1;

    logic [9:0]    shift;
    logic [3:0]    bits_left;
    logic [CW-1:0] clk_cnt;

    assign data_in_ready = (bits_left == 4'd0);
    // Idle line is high regardless of what the data shifter holds.
    assign serial_out    = data_in_ready ? 1'b1 : shift[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            bits_left <= 4'd0;
            clk_cnt   <= '0;
        end else if (data_in_valid && data_in_ready) begin
            bits_left <= 4'd10;
            clk_cnt   <= CW'(SYM - 1);
        end else if (bits_left != 4'd0) begin
            if (clk_cnt == '0) begin
                bits_left <= bits_left - 1'b1;
                clk_cnt   <= CW'(SYM - 1);
            end else begin
                clk_cnt <= clk_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (data_in_valid && data_in_ready)
            shift <= {1'b1, data_in, 1'b0};
        else if (bits_left != 4'd0 && clk_cnt == '0)
            shift <= {1'b1, shift[9:1]};
    end
endmodule

// ----------------------------------------------------------------------------
// uart_rx -- 8N1 receiver. Samples each bit mid-symbol; a completed byte is
// held with data_out_valid until accepted with data_out_ready. A frame that
// completes while the previous byte is still held overwrites it.
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready
);
    localparam int SYM = CLOCK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(SYM) + 1;

    logic          rx_s1, rx_s2;
    logic          busy;
    logic [3:0]    bit_idx;
    logic [CW-1:0] clk_cnt;
    logic [7:0]    shift;
    logic [7:0]    hold;
    logic          hold_vld;
    logic          sample;

    assign sample         = busy && (clk_cnt == '0);
    assign data_out       = hold;
    assign data_out_valid = hold_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizer resets to the idle level so reset never looks like a start bit.
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            busy     <= 1'b0;
            bit_idx  <= 4'd0;
            clk_cnt  <= '0;
            hold_vld <= 1'b0;
        end else begin
            rx_s1 <= serial_in;
            rx_s2 <= rx_s1;
            if (hold_vld && data_out_ready)
                hold_vld <= 1'b0;
            if (!busy) begin
                if (!rx_s2) begin
                    busy    <= 1'b1;
                    bit_idx <= 4'd0;
                    clk_cnt <= CW'(SYM / 2 - 1);
                end
            end else if (clk_cnt != '0) begin
                clk_cnt <= clk_cnt - 1'b1;
            end else begin
                clk_cnt <= CW'(SYM - 1);
                if (bit_idx == 4'd0 && rx_s2) begin
                    busy <= 1'b0;                  // start bit gone by mid-symbol: glitch
                end else if (bit_idx == 4'd9) begin
                    busy <= 1'b0;
                    if (rx_s2)
                        hold_vld <= 1'b1;          // only framed bytes are delivered
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sample && bit_idx >= 4'd1 && bit_idx <= 4'd8)
            shift <= {rx_s2, shift[7:1]};
        if (sample && bit_idx == 4'd9 && rx_s2)
            hold <= shift;
    end
endmodule

// ----------------------------------------------------------------------------
// uart -- ready/valid byte interface over an 8N1 serial line.
// ----------------------------------------------------------------------------
module uart #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    input  logic       serial_in,
    output logic       serial_out
);
    uart_tx #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out)
    );

    uart_rx #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );
endmodule

// ----------------------------------------------------------------------------
// mmio_uart_ctr -- top level
// ----------------------------------------------------------------------------
module mmio_uart_ctr #(
    parameter int CPU_CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE      = 115_200,
    parameter int RX_DEPTH       = 8,
    parameter int TX_DEPTH       = 8,
    parameter int CTR_W          = 32,
    parameter int NUM_EVT        = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [15:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic               inst_valid,
    input  logic [NUM_EVT-1:0] evt_in,
    input  logic               serial_in,
    output logic               serial_out
);
    localparam logic [15:0] A_CTRL = 16'h0000;
    localparam logic [15:0] A_RX   = 16'h0004;
    localparam logic [15:0] A_TX   = 16'h0008;
    localparam logic [15:0] A_CYC  = 16'h0010;
    localparam logic [15:0] A_INST = 16'h0014;
    localparam logic [15:0] A_CRST = 16'h0018;
    localparam logic [15:0] A_EVT  = 16'h0020;
    localparam int          RX_AW  = $clog2(RX_DEPTH);

    logic       rx_rd, tx_wr, crst_wr;
    logic [7:0] uart_in;
    logic       uart_in_valid, uart_in_ready;
    logic [7:0] uart_out;
    logic       uart_out_valid, uart_out_ready;
    logic       tx_ready;

    assign rx_rd   = rd_en && (addr == A_RX);
    assign tx_wr   = wr_en && (addr == A_TX);
    assign crst_wr = wr_en && (addr == A_CRST);

    // Upper write-data bits carry nothing for this peripheral.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    uart #(.CLOCK_FREQ(CPU_CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_uart (
        .clk            (clk),
        .rst            (rst),
        .data_in        (uart_in),
        .data_in_valid  (uart_in_valid),
        .data_in_ready  (uart_in_ready),
        .data_out       (uart_out),
        .data_out_valid (uart_out_valid),
        .data_out_ready (uart_out_ready),
        .serial_in      (serial_in),
        .serial_out     (serial_out)
    );

    // ---------------- RX FIFO ----------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW:0] rx_wptr, rx_rptr;
    logic           rx_empty, rx_full, rx_push, rx_pop, rx_ovf;

    assign rx_empty       = (rx_wptr == rx_rptr);
    assign rx_full        = (rx_wptr[RX_AW] != rx_rptr[RX_AW]) &&
                            (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]);
    assign uart_out_ready = !rx_full;
    assign rx_push        = uart_out_valid && !rx_full;
    assign rx_pop         = rx_rd && !rx_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wptr[RX_AW-1:0]] <= uart_out;
    end

    // Sticky: the uart keeps offering its byte while the FIFO is full.
    always_ff @(posedge clk) begin
        if (rst || crst_wr)
            rx_ovf <= 1'b0;
        else if (uart_out_valid && rx_full)
            rx_ovf <= 1'b1;
    end

    // ---------------- TX path ----------------
`ifdef MMIO_TX_FIFO_EN
    localparam int TX_AW = $clog2(TX_DEPTH);

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW:0] tx_wptr, tx_rptr;
    logic           tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty      = (tx_wptr == tx_rptr);
    assign tx_full       = (tx_wptr[TX_AW] != tx_rptr[TX_AW]) &&
                           (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]);
    assign tx_push       = tx_wr && !tx_full;      // write into a full FIFO is dropped
    assign tx_pop        = !tx_empty && uart_in_ready;
    assign uart_in       = tx_mem[tx_rptr[TX_AW-1:0]];
    assign uart_in_valid = !tx_empty;
    assign tx_ready      = !tx_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wptr[TX_AW-1:0]] <= wdata[7:0];
    end
`else
    localparam int unused_tx_depth = TX_DEPTH;

    // Single-cycle offer to the uart; lost if the transmitter is busy.
    assign uart_in       = wdata[7:0];
    assign uart_in_valid = tx_wr;
    assign tx_ready      = uart_in_ready;
`endif

    // ---------------- Counters ----------------
    logic [CTR_W-1:0] cyc;
    logic [CTR_W-1:0] inst;
    logic [CTR_W-1:0] evt [NUM_EVT];

    // A CRST write wins over every increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || crst_wr) begin
            cyc  <= '0;
            inst <= '0;
            for (int k = 0; k < NUM_EVT; k++)
                evt[k] <= '0;
        end else begin
            cyc <= cyc + 1'b1;
            if (inst_valid)
                inst <= inst + 1'b1;
            for (int k = 0; k < NUM_EVT; k++)
                if (evt_in[k])
                    evt[k] <= evt[k] + 1'b1;
        end
    end

    // ---------------- Read mux / rdata register ----------------
    // Everything is sampled from current register state, so counters read
    // their pre-increment value and CTRL reflects the rd_en cycle.
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_CTRL:  rd_mux = {29'b0, rx_ovf, !rx_empty, tx_ready};
            A_RX:    rd_mux = rx_empty ? 32'h0 : {24'b0, rx_mem[rx_rptr[RX_AW-1:0]]};
            A_CYC:   rd_mux = 32'(cyc);
            A_INST:  rd_mux = 32'(inst);
            default: rd_mux = '0;
        endcase
        for (int k = 0; k < NUM_EVT; k++)
            if (addr == A_EVT + 16'(4 * k))
                rd_mux = 32'(evt[k]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (rd_en)
            rdata <= rd_mux;
    end
endmodule

// File: tb/tb_mmio_uart_ctr.sv
module tb_mmio_uart_ctr;
    localparam int SYM     = 8;       // 800 / 100 clocks per bit
    localparam int NUM_EVT = 2;

    localparam logic [15:0] A_CTRL = 16'h0000;
    localparam logic [15:0] A_RX   = 16'h0004;
    localparam logic [15:0] A_TX   = 16'h0008;
    localparam logic [15:0] A_CYC  = 16'h0010;
    localparam logic [15:0] A_INST = 16'h0014;
    localparam logic [15:0] A_CRST = 16'h0018;
    localparam logic [15:0] A_EVT0 = 16'h0020;
    localparam logic [15:0] A_EVT1 = 16'h0024;

    logic               clk = 1'b0;
    logic               rst;
    logic               rd_en, wr_en;
    logic [15:0]        addr;
    logic [31:0]        wdata, rdata;
    logic               inst_valid;
    logic [NUM_EVT-1:0] evt_in;
    logic               serial_in, serial_out;

    mmio_uart_ctr #(
        .CPU_CLOCK_FREQ (800),
        .BAUD_RATE      (100),
        .RX_DEPTH       (8),
        .TX_DEPTH       (8),
        .CTR_W          (4),
        .NUM_EVT        (NUM_EVT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .inst_valid (inst_valid),
        .evt_in     (evt_in),
        .serial_in  (serial_in),
        .serial_out (serial_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic mmio_rd(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_en = 1'b1;
        addr  = a;
        @(negedge clk);
        rd_en = 1'b0;
        d     = rdata;
    endtask

    task automatic mmio_wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = f[i];
            repeat (SYM) @(negedge clk);
        end
    endtask

    // Serial-out monitor: collects correctly framed bytes.
    logic       mon_busy;
    int         mon_cnt;
    int         mon_bit;
    logic [7:0] mon_sh;
    logic [7:0] mon_q[$];

    always @(negedge clk) begin
        if (rst) begin
            mon_busy <= 1'b0;
        end else if (!mon_busy) begin
            if (serial_out == 1'b0) begin
                mon_busy <= 1'b1;
                mon_cnt  <= SYM + SYM / 2 - 1;
                mon_bit  <= 0;
            end
        end else if (mon_cnt != 0) begin
            mon_cnt <= mon_cnt - 1;
        end else begin
            mon_cnt <= SYM - 1;
            if (mon_bit < 8) begin
                mon_sh  <= {serial_out, mon_sh[7:1]};
                mon_bit <= mon_bit + 1;
            end else begin
                mon_busy <= 1'b0;
                if (serial_out) mon_q.push_back(mon_sh);
            end
        end
    end

    typedef struct {
        logic        rd;     // 1: read, 0: write (then exp is the held rdata)
        logic [15:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt[12];
    logic [31:0] d;
    logic [7:0]  sent[9];

    initial begin
        vt[0]  = '{1'b1, A_RX,    32'h0,        32'h0};
        vt[1]  = '{1'b1, A_CTRL,  32'h0,        32'h1};
        vt[2]  = '{1'b0, A_CTRL,  32'hFFFF_FFFF, 32'h1};
        vt[3]  = '{1'b1, A_CTRL,  32'h0,        32'h1};
        vt[4]  = '{1'b1, 16'h000C, 32'h0,       32'h0};
        vt[5]  = '{1'b1, A_CTRL,  32'h0,        32'h1};
        vt[6]  = '{1'b0, A_RX,    32'h0000_00FF, 32'h1};
        vt[7]  = '{1'b1, A_TX,    32'h0,        32'h0};
        vt[8]  = '{1'b1, A_CRST,  32'h0,        32'h0};
        vt[9]  = '{1'b1, A_EVT0,  32'h0,        32'h0};
        vt[10] = '{1'b1, 16'h0028, 32'h0,       32'h0};
        vt[11] = '{1'b1, A_EVT1,  32'h0,        32'h0};

        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
        inst_valid = 1'b0; evt_in = '0; serial_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rdata", rdata, 32'h0);
        check("reset_serial_out", {31'b0, serial_out}, 32'h1);

        // Decode / hold table
        for (int i = 0; i < 12; i++) begin
            if (vt[i].rd) begin
                mmio_rd(vt[i].a, d);
            end else begin
                mmio_wr(vt[i].a, vt[i].wd);
                d = rdata;
            end
            check($sformatf("vec%0d_addr%04h", i, vt[i].a), d, vt[i].exp);
        end

        // RX ordering
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
        repeat (4) @(negedge clk);
        mmio_rd(A_CTRL, d); check("rx3_ctrl", d, 32'h3);
        mmio_rd(A_RX, d);   check("rx3_b0", d, 32'h41);
        mmio_rd(A_RX, d);   check("rx3_b1", d, 32'h42);
        mmio_rd(A_RX, d);   check("rx3_b2", d, 32'h43);
        mmio_rd(A_RX, d);   check("rx3_empty_rd", d, 32'h0);
        mmio_rd(A_CTRL, d); check("rx3_ctrl_empty", d, 32'h1);

        // RX overflow: 9 bytes into an 8-entry FIFO
        for (int i = 0; i < 9; i++) begin
            sent[i] = 8'(8'h31 * i + 8'h07);
            send_byte(sent[i]);
        end
        repeat (4) @(negedge clk);
        mmio_rd(A_CTRL, d); check("ovf_ctrl", d, 32'h7);
        for (int i = 0; i < 8; i++) begin
            mmio_rd(A_RX, d);
            check($sformatf("ovf_b%0d", i), d, {24'b0, sent[i]});
        end
        // The held 9th byte enters the FIFO once space opens.
        mmio_wr(A_CRST, 32'h0);
        mmio_rd(A_CTRL, d); check("ovf_cleared_ctrl", d, 32'h3);
        mmio_rd(A_RX, d);   check("ovf_b8", d, {24'b0, sent[8]});
        mmio_rd(A_CTRL, d); check("ovf_drained_ctrl", d, 32'h1);

        // INST counting with alternating inst_valid (CTR_W = 4)
        mmio_wr(A_CRST, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_valid = (i % 2 == 1);
            @(negedge clk);
        end
        inst_valid = 1'b0;
        mmio_rd(A_INST, d); check("inst_50_mod16", d, 32'd2);

        // CRST overrides the same-cycle increment
        inst_valid = 1'b1;
        mmio_wr(A_CRST, 32'h0);
        @(negedge clk);
        inst_valid = 1'b0;
        rd_en = 1'b1; addr = A_CYC;
        @(negedge clk);
        rd_en = 1'b0;
        check("crst_cyc", rdata, 32'd1);
        mmio_rd(A_INST, d); check("crst_inst", d, 32'd1);

        // EVT wrap: 17 events into a 4-bit counter; evt_in[1] only during CRST
        evt_in = 2'b10;
        mmio_wr(A_CRST, 32'h0);
        evt_in = 2'b01;
        repeat (17) @(negedge clk);
        evt_in = 2'b00;
        mmio_rd(A_EVT0, d); check("evt0_wrap", d, 32'd1);
        mmio_rd(A_EVT1, d); check("evt1_crst_override", d, 32'd0);

        // Reset mid-frame discards FIFO contents and the partial byte
        send_byte(8'h5A);
        repeat (4) @(negedge clk);
        mmio_rd(A_CTRL, d); check("pre_rst_ctrl", d, 32'h3);
        serial_in = 1'b0;
        repeat (4 * SYM) @(negedge clk);
        rst = 1'b1;
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midframe_rst_rdata", rdata, 32'h0);
        repeat (12 * SYM) @(negedge clk);
        mmio_rd(A_CTRL, d); check("midframe_rst_ctrl", d, 32'h1);

        // TX back-to-back writes
        mon_q.delete();
        @(negedge clk);
        wr_en = 1'b1; addr = A_TX; wdata = 32'h0000_0055;
        @(negedge clk);
        wdata = 32'h0000_00AA;
        @(negedge clk);
        wr_en = 1'b0;
        mmio_rd(A_CTRL, d);
`ifdef MMIO_TX_FIFO_EN
        check("tx_ctrl_busy", d, 32'h1);
`else
        check("tx_ctrl_busy", d, 32'h0);
`endif
        repeat (40 * SYM) @(negedge clk);
`ifdef MMIO_TX_FIFO_EN
        check("tx_frames", mon_q.size(), 32'd2);
        if (mon_q.size() > 1) check("tx_byte1", {24'b0, mon_q[1]}, 32'hAA);
`else
        check("tx_frames", mon_q.size(), 32'd1);
`endif
        if (mon_q.size() > 0) check("tx_byte0", {24'b0, mon_q[0]}, 32'h55);
        mmio_rd(A_CTRL, d); check("tx_idle_ctrl", d, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
